intr_ctl: RTL

INTR_CTL -- requirements
Module: intr_ctl

---
 rtl/intr_ctl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/intr_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : intr_ctl
//  Description : Memory-mapped interrupt controller. Sources are level or
//                rising-edge sensitive, have a fixed priority (index 0 is
//                highest) and use a claim/complete handshake that supports
//                nesting.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_ctl #(
    parameter int NUM_SRC = 8           // legal range 1..16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               select,
    input  logic [3:0]         wr,
    input  logic               rd,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_VECTOR  = 2'd3;

    // Architectural state
    logic [NUM_SRC-1:0] pending_q,    pending_d;
    logic [NUM_SRC-1:0] enable_q,     enable_d;
    logic [NUM_SRC-1:0] mode_q,       mode_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] src_prev_q;
    logic               irq_q;

    // Decode and derived values
    logic               bus_wr;
    logic               wr_pending;
    logic               wr_enable;
    logic               wr_mode;
    logic               wr_vector;
    logic               any_active;
    logic               claim;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] lane_mask;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] edge_clr;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] complete_mask;
    logic [3:0]         best;

    // Upper data bits only matter for widths beyond NUM_SRC; this sink keeps
    // the ignored bits from appearing as dangling inputs.
    logic unused_inputs;
    assign unused_inputs = ^data_in;

    assign bus_wr     = select & (|wr);
    assign wr_pending = bus_wr & (addr == ADDR_PENDING);
    assign wr_enable  = bus_wr & (addr == ADDR_ENABLE);
    assign wr_mode    = bus_wr & (addr == ADDR_MODE);
    assign wr_vector  = bus_wr & (addr == ADDR_VECTOR);

    assign wdata      = data_in[NUM_SRC-1:0];
    assign active     = pending_q & enable_q & ~in_service_q;
    assign any_active = |active;
    assign claim      = select & rd & (addr == ADDR_VECTOR) & any_active;
    assign edge_set   = src & ~src_prev_q;
    assign irq        = irq_q;

    // Byte-lane write mask: bits 7:0 follow wr[0], bits 15:8 follow wr[1]
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i < 8) lane_mask[i] = wr[0];
            else       lane_mask[i] = wr[1];
        end
    end

    // Fixed priority: lowest active index wins
    always_comb begin
        best = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) best = 4'(i);
        end
    end

    // One-hot masks for the claimed source and a valid completion
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i]    = claim & (best == 4'(i));
            // An id at or above NUM_SRC never matches any loop index, so it
            // falls out as an ignored completion.
            complete_mask[i] = wr_vector & (data_in[3:0] == 4'(i)) & in_service_q[i];
        end
    end

    // Next-state for pending, enable, mode and in-service sets
    always_comb begin
        edge_clr     = ({NUM_SRC{wr_pending}} & wdata) | complete_mask;
        enable_d     = enable_q;
        mode_d       = mode_q;
        pending_d    = pending_q;
        in_service_d = (in_service_q | claim_mask) & ~complete_mask;

        if (wr_enable) enable_d = (enable_q & ~lane_mask) | (wdata & lane_mask);
        if (wr_mode)   mode_d   = (mode_q   & ~lane_mask) | (wdata & lane_mask);

        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                // Edge mode: a new edge beats a simultaneous clear
                pending_d[i] = edge_set[i] | (pending_q[i] & ~edge_clr[i]);
            end else begin
                // Level mode: pending simply mirrors the request line
                pending_d[i] = src[i];
            end
        end
    end

    // State registers with synchronous reset; irq is the registered OR of active
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
            src_prev_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
            src_prev_q   <= src;
            irq_q        <= any_active;
        end
    end

    // Register read mux; bits above NUM_SRC read as zero
    always_comb begin
        data_out = 32'd0;
        case (addr)
            ADDR_PENDING: data_out = {{(32-NUM_SRC){1'b0}}, pending_q};
            ADDR_ENABLE:  data_out = {{(32-NUM_SRC){1'b0}}, enable_q};
            ADDR_MODE:    data_out = {{(32-NUM_SRC){1'b0}}, mode_q};
            ADDR_VECTOR:  data_out = {any_active, 27'd0, best};
            default:      data_out = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
